// File: rtl/csc_row_gen.sv
// csc_row_gen: turns one steering request (z0, z1, s, a0, a1) into a sorted CSC row of 2 or 4 entries.
// Build option CSC_ROWCNT_EN adds the row_cnt / col_ptr bookkeeping outputs.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | complex products being registered
// EMIT  | streaming the row's entries downstream
`timescale 1ns/1ps
module csc_row_gen #(
  parameter int DW       = 32,
  parameter int MAT_RANK = 256,
  parameter int IDX_W    = $clog2(MAT_RANK),
  parameter int SHIFT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [IDX_W-1:0]     z0,
  input  logic [IDX_W-1:0]     z1,
  input  logic signed [DW-1:0] s_r,
  input  logic signed [DW-1:0] s_i,
  input  logic signed [DW-1:0] a0_r,
  input  logic signed [DW-1:0] a0_i,
  input  logic signed [DW-1:0] a1_r,
  input  logic signed [DW-1:0] a1_i,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [IDX_W-1:0]     out_idx,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 out_last,
  output logic                 err
`ifdef CSC_ROWCNT_EN
  ,
  output logic [IDX_W-1:0]     row_cnt,
  output logic [IDX_W+2:0]     col_ptr
`endif
);

  localparam int PRW = 2*DW + 1;
  localparam int PW  = 2*DW + 2;
  localparam logic [IDX_W-1:0] HALF = IDX_W'(MAT_RANK/2);

  typedef enum logic [1:0] {IDLE, MUL, EMIT} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]     z0_q, z1_q;
  logic signed [DW-1:0] s_r_q, s_i_q, a0_r_q, a0_i_q, a1_r_q, a1_i_q;
  logic signed [PRW-1:0] p0_r_q, p0_i_q, p1_r_q, p1_i_q;
  logic signed [PRW-1:0] p0_r_c, p0_i_c, p1_r_c, p1_i_c;
  logic [1:0]           beat_q;
  logic                 err_q;
  logic                 bad_z;

  logic signed [PW-1:0] e0_r, e0_i, e1_r, e1_i;
  logic signed [PW-1:0] lo_r, lo_i, hi_r, hi_i, lo_ur, lo_ui, hi_ur, hi_ui;
  logic signed [PW-1:0] ent_r, ent_i;
  logic [IDX_W-1:0]     lo_z, hi_z, ent_idx;
  logic                 merged, ordered, last_c;

  assign bad_z = (z0 >= HALF) || (z1 >= HALF);
  assign err   = err_q;

  assign p0_r_c = PRW'(a0_r_q) * PRW'(s_r_q) - PRW'(a0_i_q) * PRW'(s_i_q);
  assign p0_i_c = PRW'(a0_r_q) * PRW'(s_i_q) + PRW'(a0_i_q) * PRW'(s_r_q);
  assign p1_r_c = PRW'(a1_r_q) * PRW'(s_r_q) - PRW'(a1_i_q) * PRW'(s_i_q);
  assign p1_i_c = PRW'(a1_r_q) * PRW'(s_i_q) + PRW'(a1_i_q) * PRW'(s_r_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_vld && !bad_z) state_nxt = MUL;
      MUL:     state_nxt = EMIT;
      EMIT:    if (out_rdy && last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_idx  = '0;
    out_r    = '0;
    out_i    = '0;
    out_last = 1'b0;
    case (state)
      IDLE: in_rdy = !rst;
      EMIT: begin
        out_vld  = 1'b1;
        out_idx  = ent_idx;
        out_r    = DW'(ent_r >>> SHIFT);
        out_i    = DW'(ent_i >>> SHIFT);
        out_last = last_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z0_q   <= '0;
      z1_q   <= '0;
      s_r_q  <= '0;
      s_i_q  <= '0;
      a0_r_q <= '0;
      a0_i_q <= '0;
      a1_r_q <= '0;
      a1_i_q <= '0;
      p0_r_q <= '0;
      p0_i_q <= '0;
      p1_r_q <= '0;
      p1_i_q <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && in_vld && bad_z;
      if (state == IDLE && in_vld) begin
        z0_q   <= z0;
        z1_q   <= z1;
        s_r_q  <= s_r;
        s_i_q  <= s_i;
        a0_r_q <= a0_r;
        a0_i_q <= a0_i;
        a1_r_q <= a1_r;
        a1_i_q <= a1_i;
      end
      if (state == MUL) begin
        p0_r_q <= p0_r_c;
        p0_i_q <= p0_i_c;
        p1_r_q <= p1_r_c;
        p1_i_q <= p1_i_c;
        beat_q <= '0;
      end else if (state == EMIT && out_rdy) begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // lo/hi name the smaller/larger base column; the upper-half copy of the z1 term is negated
  always_comb begin
    e0_r    = PW'(p0_r_q);
    e0_i    = PW'(p0_i_q);
    e1_r    = PW'(p1_r_q);
    e1_i    = PW'(p1_i_q);
    merged  = (z0_q == z1_q);
    ordered = (z0_q < z1_q);
    lo_z    = ordered ? z0_q : z1_q;
    hi_z    = ordered ? z1_q : z0_q;
    lo_r    = ordered ? e0_r : e1_r;
    lo_i    = ordered ? e0_i : e1_i;
    hi_r    = ordered ? e1_r : e0_r;
    hi_i    = ordered ? e1_i : e0_i;
    lo_ur   = ordered ? e0_r : -e1_r;
    lo_ui   = ordered ? e0_i : -e1_i;
    hi_ur   = ordered ? -e1_r : e0_r;
    hi_ui   = ordered ? -e1_i : e0_i;
    last_c  = merged ? (beat_q == 2'd1) : (beat_q == 2'd3);
    ent_idx = '0;
    ent_r   = '0;
    ent_i   = '0;
    if (merged) begin
      if (beat_q == 2'd0) begin
        ent_idx = z0_q;
        ent_r   = e0_r + e1_r;
        ent_i   = e0_i + e1_i;
      end else begin
        ent_idx = z0_q + HALF;
        ent_r   = e0_r - e1_r;
        ent_i   = e0_i - e1_i;
      end
    end else begin
      case (beat_q)
        2'd0: begin ent_idx = lo_z;        ent_r = lo_r;  ent_i = lo_i;  end
        2'd1: begin ent_idx = hi_z;        ent_r = hi_r;  ent_i = hi_i;  end
        2'd2: begin ent_idx = lo_z + HALF; ent_r = lo_ur; ent_i = lo_ui; end
        default: begin ent_idx = hi_z + HALF; ent_r = hi_ur; ent_i = hi_ui; end
      endcase
    end
  end

`ifdef CSC_ROWCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      col_ptr <= '0;
    end else if (out_vld && out_rdy) begin
      col_ptr <= col_ptr + (IDX_W+3)'(1);
      if (out_last) row_cnt <= row_cnt + IDX_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_csc_row_gen.sv
// Bench for csc_row_gen: a merge-and-sort row model feeds a per-beat checker; directed rows pin the model.
`timescale 1ns/1ps
module tb_csc_row_gen;
  localparam int DW = 32, MAT_RANK = 256, IDX_W = 8, SHIFT = 1, H = MAT_RANK/2;

  logic clk = 1'b0;
  logic rst, in_vld, in_rdy, out_vld, out_rdy, out_last, err;
  logic [IDX_W-1:0] z0, z1, out_idx;
  logic [DW-1:0] s_r, s_i, a0_r, a0_i, a1_r, a1_i, out_r, out_i;
`ifdef CSC_ROWCNT_EN
  logic [IDX_W-1:0] row_cnt;
  logic [IDX_W+2:0] col_ptr;
`endif

  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  csc_row_gen #(.DW(DW), .MAT_RANK(MAT_RANK), .IDX_W(IDX_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .z0(z0), .z1(z1),
    .s_r(s_r), .s_i(s_i), .a0_r(a0_r), .a0_i(a0_i), .a1_r(a1_r), .a1_i(a1_i),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx), .out_r(out_r), .out_i(out_i),
    .out_last(out_last), .err(err)
`ifdef CSC_ROWCNT_EN
    , .row_cnt(row_cnt), .col_ptr(col_ptr)
`endif
  );

  logic [IDX_W-1:0] exp_idx[$], obs_idx[$];
  logic [DW-1:0]    exp_r[$], exp_i[$], obs_r[$], obs_i[$];
  logic             exp_last[$], obs_last[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Row model: drop the four terms at their columns, merge collisions, sort by column, scale.
  task automatic model_push(input int z0v, input int z1v, input longint sr, input longint si,
                            input longint a0r, input longint a0i, input longint a1r, input longint a1i);
    longint p0r, p0i, p1r, p1i, tr, tq;
    int ki[4], ui[4], n, f, ti;
    longint kr[4], kq[4], ur[4], uq[4];
    p0r = a0r*sr - a0i*si;  p0i = a0r*si + a0i*sr;
    p1r = a1r*sr - a1i*si;  p1i = a1r*si + a1i*sr;
    ki = '{z0v, z1v, z0v + H, z1v + H};
    kr = '{p0r, p1r, p0r, -p1r};
    kq = '{p0i, p1i, p0i, -p1i};
    n = 0;
    for (int k = 0; k < 4; k++) begin
      f = -1;
      for (int j = 0; j < n; j++) if (ui[j] == ki[k]) f = j;
      if (f >= 0) begin
        ur[f] += kr[k];
        uq[f] += kq[k];
      end else begin
        ui[n] = ki[k]; ur[n] = kr[k]; uq[n] = kq[k]; n++;
      end
    end
    for (int a = 0; a < n; a++)
      for (int b = 0; b < n - 1 - a; b++)
        if (ui[b] > ui[b+1]) begin
          ti = ui[b]; ui[b] = ui[b+1]; ui[b+1] = ti;
          tr = ur[b]; ur[b] = ur[b+1]; ur[b+1] = tr;
          tq = uq[b]; uq[b] = uq[b+1]; uq[b+1] = tq;
        end
    for (int k = 0; k < n; k++) begin
      exp_idx.push_back(IDX_W'(ui[k]));
      exp_r.push_back(DW'(ur[k] >>> SHIFT));
      exp_i.push_back(DW'(uq[k] >>> SHIFT));
      exp_last.push_back(k == n - 1);
    end
  endtask

  logic             held;
  logic [IDX_W-1:0] h_idx;
  logic [DW-1:0]    h_r, h_i;
  logic             h_last;
  int               exp_row, exp_col;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
      exp_row = 0;
      exp_col = 0;
    end else begin
`ifdef CSC_ROWCNT_EN
      chk("row_cnt", row_cnt, exp_row);
      chk("col_ptr", col_ptr, exp_col);
`endif
      if (held) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_idx", out_idx, h_idx);
        chk("hold_r", out_r, h_r);
        chk("hold_i", out_i, h_i);
        chk("hold_last", out_last, h_last);
      end
      if (out_vld) chk("busy_in_rdy", in_rdy, 0);
      if (out_vld && out_rdy) begin
        obs_idx.push_back(out_idx);
        obs_r.push_back(out_r);
        obs_i.push_back(out_i);
        obs_last.push_back(out_last);
        if (exp_idx.size() == 0) chk("unexpected_beat", out_vld, 0);
        else begin
          chk("beat_idx", out_idx, exp_idx.pop_front());
          chk("beat_r", out_r, exp_r.pop_front());
          chk("beat_i", out_i, exp_i.pop_front());
          chk("beat_last", out_last, exp_last.pop_front());
        end
        exp_col++;
        if (out_last) exp_row = (exp_row + 1) % MAT_RANK;
      end
      held = out_vld && !out_rdy;
      h_idx = out_idx; h_r = out_r; h_i = out_i; h_last = out_last;
    end
  end

  task automatic clear_obs();
    obs_idx.delete(); obs_r.delete(); obs_i.delete(); obs_last.delete();
  endtask

  task automatic send(input int z0v, input int z1v, input longint sr, input longint si,
                      input longint a0r, input longint a0i, input longint a1r, input longint a1i,
                      input bit ok);
    int n = 0;
    while (in_rdy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_in_rdy", in_rdy, 1);
    z0 = IDX_W'(z0v); z1 = IDX_W'(z1v);
    s_r = DW'(sr); s_i = DW'(si); a0_r = DW'(a0r); a0_i = DW'(a0i); a1_r = DW'(a1r); a1_i = DW'(a1i);
    in_vld = 1'b1;
    if (ok) model_push(z0v, z1v, sr, si, a0r, a0i, a1r, a1i);
    @(posedge clk); #1;
    in_vld = 1'b0;
    if (ok) begin
      chk("lat_mul_vld", out_vld, 0);
      chk("lat_mul_in_rdy", in_rdy, 0);
      chk("lat_mul_err", err, 0);
      @(posedge clk); #1;
      chk("lat_first_vld", out_vld, 1);
    end else begin
      chk("rej_err_pulse", err, 1);
      chk("rej_vld", out_vld, 0);
      chk("rej_in_rdy", in_rdy, 1);
      @(posedge clk); #1;
      chk("rej_err_clear", err, 0);
      chk("rej_vld2", out_vld, 0);
      chk("rej_in_rdy2", in_rdy, 1);
    end
  endtask

  task automatic wait_row_done();
    int n = 0;
    while ((exp_idx.size() != 0 || out_vld) && n < 100) begin @(posedge clk); #1; n++; end
    chk("row_done_timeout", exp_idx.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_first_beat();
    int n = 0;
    while (obs_idx.size() < 1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("first_beat_timeout", obs_idx.size(), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    z0 = '0; z1 = '0; s_r = '0; s_i = '0; a0_r = '0; a0_i = '0; a1_r = '0; a1_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_i", out_i, 0);
    rst = 1'b0;
    #1;
    chk("release_in_rdy", in_rdy, 1);
    @(posedge clk); #1;

    // basic ascending row
    clear_obs();
    send(3, 10, 2, 0, 4, 2, 1, -3, 1);
    wait_row_done();
    chk("basic_count", obs_idx.size(), 4);
    if (obs_idx.size() == 4) begin
      chk("basic_idx0", obs_idx[0], 3);
      chk("basic_idx1", obs_idx[1], 10);
      chk("basic_idx2", obs_idx[2], 131);
      chk("basic_idx3", obs_idx[3], 138);
      chk("basic_r0", obs_r[0], 4);
      chk("basic_i0", obs_i[0], 2);
      chk("basic_i1", obs_i[1], 32'hFFFF_FFFD);
      chk("basic_r3", obs_r[3], 32'hFFFF_FFFF);
      chk("basic_i3", obs_i[3], 3);
      chk("basic_last0", obs_last[0], 0);
      chk("basic_last2", obs_last[2], 0);
      chk("basic_last3", obs_last[3], 1);
    end

    // swapped order
    clear_obs();
    send(10, 3, 2, 0, 4, 2, 1, -3, 1);
    wait_row_done();
    chk("swap_count", obs_idx.size(), 4);
    if (obs_idx.size() == 4) begin
      chk("swap_idx0", obs_idx[0], 3);
      chk("swap_idx3", obs_idx[3], 138);
      chk("swap_r0", obs_r[0], 1);
      chk("swap_r1", obs_r[1], 4);
      chk("swap_r2", obs_r[2], 32'hFFFF_FFFF);
      chk("swap_i2", obs_i[2], 3);
      chk("swap_r3", obs_r[3], 4);
    end

    // merged row
    clear_obs();
    send(5, 5, 2, 0, 4, 0, 2, 0, 1);
    wait_row_done();
    chk("merge_count", obs_idx.size(), 2);
    if (obs_idx.size() == 2) begin
      chk("merge_idx0", obs_idx[0], 5);
      chk("merge_r0", obs_r[0], 6);
      chk("merge_i0", obs_i[0], 0);
      chk("merge_idx1", obs_idx[1], 133);
      chk("merge_r1", obs_r[1], 2);
      chk("merge_last0", obs_last[0], 0);
      chk("merge_last1", obs_last[1], 1);
    end

    // boundary columns and wide products that truncate
    send(127, 0, 100000, -3, 70000, 12345, -50000, 99999, 1);
    wait_row_done();
    send(0, 127, -77777, 4242, 123456, -654321, 99, -1, 1);
    wait_row_done();
    send(127, 127, -5, -7, 31, -2, -9, 13, 1);
    wait_row_done();

    // backpressure on beat 2, with a request presented while busy
    clear_obs();
    send(3, 10, 2, 0, 4, 2, 1, -3, 1);
    wait_first_beat();
    out_rdy = 1'b0;
    z0 = 8'd1; z1 = 8'd2; in_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    wait_row_done();
    chk("bp_count", obs_idx.size(), 4);
    if (obs_idx.size() == 4) begin
      chk("bp_idx1", obs_idx[1], 10);
      chk("bp_idx2", obs_idx[2], 131);
    end

    // rejects at the column boundary
    send(200, 4, 2, 0, 4, 2, 1, -3, 0);
    send(4, 128, 2, 0, 4, 2, 1, -3, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset during beat 2
    clear_obs();
    send(3, 10, 2, 0, 4, 2, 1, -3, 1);
    wait_first_beat();
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_in_rdy", in_rdy, 0);
    exp_idx.delete(); exp_r.delete(); exp_i.delete(); exp_last.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_in_rdy", in_rdy, 1);
    chk("mid_rel_vld", out_vld, 0);
    @(posedge clk); #1;
    clear_obs();
    send(5, 5, 2, 0, 4, 0, 2, 0, 1);
    wait_row_done();
    chk("after_rst_count", obs_idx.size(), 2);
`ifdef CSC_ROWCNT_EN
    chk("after_rst_row_cnt", row_cnt, 1);
    chk("after_rst_col_ptr", col_ptr, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csc_row_gen.md
Name: csc_row_gen

Overview:
- Parametrised successor to the fixed 4-register CSC row store.
- Takes one steering request per row: column indices z0 and z1, scalar s, coefficients a0 and a1, all complex.
- Computes the complex products and builds the row's nonzero entries at z0, z1, z0+N/2 and z1+N/2.
- Streams the entries as sorted (index, value) CSC tuples over a valid/ready interface to the downstream matrix packer.

Parameters:
- DW, 32, width of each real/imag component (input and output)
- MAT_RANK, 256, matrix dimension N; must be a power of 2, >= 4
- IDX_W, $clog2(MAT_RANK), column-index width
- SHIFT, 1, arithmetic right shift applied to every result before truncation to DW

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- in_vld  in  1  request valid
- in_rdy  out  1  block can accept a request
- z0  in  IDX_W  column index of a0 term
- z1  in  IDX_W  column index of a1 term
- s_r, s_i  in  DW each  scalar, signed
- a0_r, a0_i  in  DW each  coefficient 0, signed
- a1_r, a1_i  in  DW each  coefficient 1, signed
- out_vld  out  1  entry valid
- out_rdy  in  1  downstream accepts entry
- out_idx  out  IDX_W  column index of entry
- out_r, out_i  out  DW each  entry value, signed
- out_last  out  1  final entry of the current row
- err  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset values: in_rdy=0 while rst is high, 1 in the first cycle after release. out_vld=0, out_last=0, err=0. out_idx, out_r, out_i = 0. FSM in IDLE.
- FSM states: IDLE, MUL, EMIT.
  - IDLE: in_rdy=1. On in_vld, capture all inputs.
    - If z0 >= N/2 or z1 >= N/2: pulse err next cycle, stay in IDLE, emit nothing.
    - Otherwise go to MUL.
  - MUL: in_rdy=0. Register p0 = a0*s and p1 = a1*s, 2*DW+1 bits signed. Build the entry list. Go to EMIT.
  - EMIT: in_rdy=0. Present entries in order, one per accepted beat (out_vld && out_rdy). After the beat with out_last=1, go to IDLE.
- Complex product: re = ar*sr - ai*si, im = ar*si + ai*sr, full precision.
- Result scaling: value = (x >>> SHIFT)[DW-1:0]. Sums are formed at full precision before the shift. Truncation only, no saturation.
- Entry list when z0 < z1 (4 entries):
  - (z0, p0), (z1, p1), (z0+N/2, p0), (z1+N/2, -p1)
- Entry list when z0 > z1 (4 entries, sorted ascending):
  - (z1, p1), (z0, p0), (z1+N/2, -p1), (z0+N/2, p0)
- Entry list when z0 == z1 (2 entries, merged):
  - (z0, p0+p1), (z0+N/2, p0-p1)
- Latency: request accepted at cycle T; first out_vld at T+2. The minimum row period is (entries + 2) cycles.
- Backpressure: while out_vld=1 and out_rdy=0, out_idx, out_r, out_i and out_last hold stable. out_vld never drops without a handshake.
- out_last is high only on the final entry: the 4th entry of a 4-entry row, the 2nd of a merged row.
- Requests presented while in_rdy=0 are ignored; no buffering.
- Reset mid-row: all state is discarded immediately. out_vld falls asynchronously, and no partial row resumes.

Optional Feature:
- Macro: CSC_ROWCNT_EN.
- Defined: adds two outputs.
  - row_cnt (IDX_W): increments on each out_last handshake and wraps to 0 after MAT_RANK-1.
  - col_ptr (IDX_W+3): running count of emitted entries, i.e. the CSC pointer. Increments on every out handshake.
  - Both are 0 on reset. A rejected request (err) changes neither.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Basic, out_rdy tied 1, DW=32, SHIFT=1, N=256: z0=3, z1=10, s=(2,0), a0=(4,2), a1=(1,-3).
  - Expect at T+2..T+5: (3, 4, 2), (10, 1, -3), (131, 4, 2), (138, -1, 3).
  - out_last on the 4th beat only.
- Swapped order: z0=10, z1=3, same values.
  - Expect index order 3, 10, 131, 138 with values p1, p0, -p1, p0.
- Merged: z0=z1=5, s=(2,0), a0=(4,0), a1=(2,0).
  - Expect exactly 2 beats: (5, 6, 0), (133, 2, 0), out_last on beat 2.
- Backpressure: hold out_rdy=0 for 3 cycles on beat 2.
  - Outputs stay stable, in_rdy stays 0, no beat is lost or duplicated.
- Reject: z0=200.
  - err pulses one cycle, no out_vld, in_rdy remains 1.
  - With CSC_ROWCNT_EN, row_cnt and col_ptr are unchanged.
- Reset mid-row: assert rst during beat 2.
  - out_vld goes to 0 immediately, and in_rdy=1 in the first cycle after release.
  - A new request then completes normally, with counters (if enabled) restarting from 0.
